// File: rtl/msx_slot_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : msx_slot_io_responder_if
// Brief    : Internal CPU-bus request/response bundle between the MSX slot
//            I/O responder (master) and the VDP register block (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface msx_slot_io_responder_if;
  logic       bus_valid;
  logic       bus_ready;
  logic       bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  // Responder side: issues requests, consumes ready and read data
  modport master (
    output bus_valid,
    output bus_write,
    output bus_address,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata,
    input  bus_rdata_en
  );

  // VDP side: accepts requests, returns read data
  modport slave (
    input  bus_valid,
    input  bus_write,
    input  bus_address,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata,
    output bus_rdata_en
  );
endinterface
`default_nettype wire

// File: rtl/msx_slot_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : msx_slot_io_responder
// Brief    : Cartridge-side responder for Z80 slot I/O cycles. Synchronizes
//            the slot strobes, decodes a 4-port I/O window and converts each
//            slot cycle into exactly one valid/ready transaction toward the
//            VDP. Reads hold /WAIT until the VDP returns data, then drive the
//            data bus until /IORQ rises.
// Revision : 1.0 - initial release
// ============================================================================
module msx_slot_io_responder #(
  parameter logic [7:0] IO_BASE     = 8'h88,
  parameter logic [7:0] IO_MASK     = 8'hFC,
  parameter int         SYNC_STAGES = 2
) (
  input  wire        clk,
  input  wire        reset_n,
  input  wire        slot_iorq_n,
  input  wire        slot_rd_n,
  input  wire        slot_wr_n,
  input  wire  [7:0] slot_a,
  input  wire  [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  output logic       slot_wait,
  msx_slot_io_responder_if.master bus
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_REQ     = 2'd1;
  localparam logic [1:0] c_ST_RD_WAIT = 2'd2;
  localparam logic [1:0] c_ST_HOLD    = 2'd3;

  // Bit order of each synchronizer stage: {iorq, rd, wr}
  logic [2:0] strobe_sync_q [SYNC_STAGES];

  logic [1:0] state_q, state_d;
  logic       bus_valid_q, bus_valid_d;
  logic       bus_write_q, bus_write_d;
  logic [1:0] bus_address_q, bus_address_d;
  logic [7:0] bus_wdata_q, bus_wdata_d;
  logic       slot_wait_q, slot_wait_d;
  logic       slot_data_dir_q, slot_data_dir_d;
  logic [7:0] slot_d_out_q, slot_d_out_d;
  // Set once the CPU has released /IORQ before the transaction finished
  logic       aborted_q, aborted_d;

  logic w_iorq_s;
  logic w_rd_s;
  logic w_wr_s;
  logic w_match;
  logic w_start;
  logic w_handshake;
  logic w_abandon;

  assign w_iorq_s    = strobe_sync_q[SYNC_STAGES-1][2];
  assign w_rd_s      = strobe_sync_q[SYNC_STAGES-1][1];
  assign w_wr_s      = strobe_sync_q[SYNC_STAGES-1][0];
  assign w_match     = ((slot_a & IO_MASK) == IO_BASE);
  assign w_start     = !w_iorq_s && (!w_rd_s || !w_wr_s) && w_match;
  assign w_handshake = bus_valid_q && bus.bus_ready;
  // Read data must not be driven if the CPU has already left the cycle
  assign w_abandon   = aborted_q || w_iorq_s;

  // Strobe synchronizer chain, preset to the inactive (high) level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        strobe_sync_q[i] <= 3'b111;
      end
    end else begin
      strobe_sync_q[0] <= {slot_iorq_n, slot_rd_n, slot_wr_n};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        strobe_sync_q[i] <= strobe_sync_q[i-1];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= c_ST_IDLE;
      bus_valid_q     <= 1'b0;
      bus_write_q     <= 1'b0;
      bus_address_q   <= 2'd0;
      bus_wdata_q     <= 8'd0;
      slot_wait_q     <= 1'b0;
      slot_data_dir_q <= 1'b0;
      slot_d_out_q    <= 8'd0;
      aborted_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      bus_valid_q     <= bus_valid_d;
      bus_write_q     <= bus_write_d;
      bus_address_q   <= bus_address_d;
      bus_wdata_q     <= bus_wdata_d;
      slot_wait_q     <= slot_wait_d;
      slot_data_dir_q <= slot_data_dir_d;
      slot_d_out_q    <= slot_d_out_d;
      aborted_q       <= aborted_d;
    end
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_start) begin
          state_d = c_ST_REQ;
        end
      end
      c_ST_REQ: begin
        if (w_handshake) begin
          if (bus_write_q) begin
            state_d = c_ST_HOLD;
          end else if (bus.bus_rdata_en) begin
            state_d = w_abandon ? c_ST_IDLE : c_ST_HOLD;
          end else begin
            state_d = c_ST_RD_WAIT;
          end
        end
      end
      c_ST_RD_WAIT: begin
        if (bus.bus_rdata_en) begin
          state_d = w_abandon ? c_ST_IDLE : c_ST_HOLD;
        end
      end
      c_ST_HOLD: begin
        if (w_iorq_s) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // Next values of the bus request, wait and data-drive outputs
  always_comb begin
    bus_valid_d     = bus_valid_q;
    bus_write_d     = bus_write_q;
    bus_address_d   = bus_address_q;
    bus_wdata_d     = bus_wdata_q;
    slot_wait_d     = slot_wait_q;
    slot_data_dir_d = slot_data_dir_q;
    slot_d_out_d    = slot_d_out_q;
    aborted_d       = aborted_q;
    case (state_q)
      c_ST_IDLE: begin
        aborted_d = 1'b0;
        if (w_start) begin
          // A cycle with both strobes low is treated as a write
          bus_address_d = slot_a[1:0];
          bus_valid_d   = 1'b1;
          bus_write_d   = !w_wr_s;
          if (!w_wr_s) begin
            bus_wdata_d = slot_d_in;
          end else begin
            slot_wait_d = 1'b1;
          end
        end
      end
      c_ST_REQ: begin
        if (w_iorq_s) begin
          slot_wait_d = 1'b0;
          aborted_d   = 1'b1;
        end
        if (w_handshake) begin
          bus_valid_d = 1'b0;
          // Zero-latency read: data accompanies the handshake
          if (!bus_write_q && bus.bus_rdata_en) begin
            slot_d_out_d    = bus.bus_rdata;
            slot_data_dir_d = !w_abandon;
            slot_wait_d     = 1'b0;
          end
        end
      end
      c_ST_RD_WAIT: begin
        if (w_iorq_s) begin
          slot_wait_d = 1'b0;
          aborted_d   = 1'b1;
        end
        if (bus.bus_rdata_en) begin
          slot_d_out_d    = bus.bus_rdata;
          slot_data_dir_d = !w_abandon;
          slot_wait_d     = 1'b0;
        end
      end
      c_ST_HOLD: begin
        if (w_iorq_s) begin
          slot_data_dir_d = 1'b0;
        end
      end
      default: begin
        bus_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.bus_valid   = bus_valid_q;
  assign bus.bus_write   = bus_write_q;
  assign bus.bus_address = bus_address_q;
  assign bus.bus_wdata   = bus_wdata_q;
  assign slot_wait       = slot_wait_q;
  assign slot_data_dir   = slot_data_dir_q;
  assign slot_d_out      = slot_d_out_q;

endmodule
`default_nettype wire

// File: tb/tb_msx_slot_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_msx_slot_io_responder
// Brief    : Directed self-checking bench for msx_slot_io_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msx_slot_io_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       iorq_n, rd_n, wr_n;
  logic [7:0] a, din;
  logic [7:0] dout;
  logic       dir, wait_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Handshake log
  int         hs_count = 0;
  logic [1:0] log_addr  [64];
  logic       log_wr    [64];
  logic [7:0] log_wdata [64];

  msx_slot_io_responder_if bus_if ();

  msx_slot_io_responder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .slot_iorq_n   (iorq_n),
    .slot_rd_n     (rd_n),
    .slot_wr_n     (wr_n),
    .slot_a        (a),
    .slot_d_in     (din),
    .slot_d_out    (dout),
    .slot_data_dir (dir),
    .slot_wait     (wait_o),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  // Record every accepted transaction
  always @(posedge clk) begin
    if (reset_n && bus_if.bus_valid && bus_if.bus_ready) begin
      if (hs_count < 64) begin
        log_addr[hs_count]  = bus_if.bus_address;
        log_wr[hs_count]    = bus_if.bus_write;
        log_wdata[hs_count] = bus_if.bus_wdata;
      end
      hs_count = hs_count + 1;
    end
  end

  task automatic test_reset();
    reset_n = 1'b1;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a = 8'h00; din = 8'h00;
    bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 8'h00; bus_if.bus_rdata_en = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus_if.bus_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus_if.bus_valid); else n_pass++;
    n_checks++; if (bus_if.bus_write !== 1'b0) $display("FAIL reset_write: got %b expected 0", bus_if.bus_write); else n_pass++;
    n_checks++; if (bus_if.bus_address !== 2'd0) $display("FAIL reset_addr: got %h expected 0", bus_if.bus_address); else n_pass++;
    n_checks++; if (bus_if.bus_wdata !== 8'h00) $display("FAIL reset_wdata: got %h expected 00", bus_if.bus_wdata); else n_pass++;
    n_checks++; if (wait_o !== 1'b0) $display("FAIL reset_wait: got %b expected 0", wait_o); else n_pass++;
    n_checks++; if (dir !== 1'b0) $display("FAIL reset_dir: got %b expected 0", dir); else n_pass++;
    n_checks++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int  h0;
    bit  bad;
    h0 = hs_count; bad = 1'b0;
    bus_if.bus_ready = 1'b1;
    @(negedge clk);
    a = 8'h89; din = 8'h8F; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (10) begin @(negedge clk); if (wait_o !== 1'b0 || dir !== 1'b0) bad = 1'b1; end
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (6) begin @(negedge clk); if (wait_o !== 1'b0 || dir !== 1'b0) bad = 1'b1; end
    n_checks++; if (hs_count - h0 !== 1) $display("FAIL wr_count: got %0d expected 1", hs_count - h0); else n_pass++;
    n_checks++; if (log_addr[h0] !== 2'd1) $display("FAIL wr_addr: got %0d expected 1", log_addr[h0]); else n_pass++;
    n_checks++; if (log_wr[h0] !== 1'b1) $display("FAIL wr_dir: got %b expected 1", log_wr[h0]); else n_pass++;
    n_checks++; if (log_wdata[h0] !== 8'h8F) $display("FAIL wr_data: got %h expected 8f", log_wdata[h0]); else n_pass++;
    n_checks++; if (bad !== 1'b0) $display("FAIL wr_wait_dir: got 1 expected 0 (wait/dir asserted)"); else n_pass++;
    n_checks++; if (bus_if.bus_valid !== 1'b0) $display("FAIL wr_valid_end: got %b expected 0", bus_if.bus_valid); else n_pass++;
  endtask

  task automatic test_read();
    int  h0, k, t;
    bit  bad;
    h0 = hs_count;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata_en = 1'b0;
    @(negedge clk);
    a = 8'h89; iorq_n = 1'b0; rd_n = 1'b0;
    k = 0;
    while (wait_o !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_checks++; if (!(wait_o === 1'b1 && k <= 3)) $display("FAIL rd_wait_rise: got %0d clocks expected <=3", k); else n_pass++;
    t = 0;
    while (hs_count == h0 && t < 10) begin @(negedge clk); t++; end
    bad = 1'b0;
    repeat (20) begin @(negedge clk); if (wait_o !== 1'b1 || dir !== 1'b0) bad = 1'b1; end
    n_checks++; if (bad !== 1'b0) $display("FAIL rd_wait_hold: got wait dropped expected held"); else n_pass++;
    bus_if.bus_rdata = 8'h5A; bus_if.bus_rdata_en = 1'b1;
    @(negedge clk);
    bus_if.bus_rdata_en = 1'b0; bus_if.bus_rdata = 8'h00;
    n_checks++; if (wait_o !== 1'b0) $display("FAIL rd_wait_fall: got %b expected 0", wait_o); else n_pass++;
    n_checks++; if (dir !== 1'b1) $display("FAIL rd_dir_on: got %b expected 1", dir); else n_pass++;
    n_checks++; if (dout !== 8'h5A) $display("FAIL rd_dout: got %h expected 5a", dout); else n_pass++;
    bad = 1'b0;
    repeat (5) begin @(negedge clk); if (dir !== 1'b1 || dout !== 8'h5A) bad = 1'b1; end
    n_checks++; if (bad !== 1'b0) $display("FAIL rd_drive_hold: got drive lost expected held"); else n_pass++;
    iorq_n = 1'b1; rd_n = 1'b1;
    t = 0;
    while (dir !== 1'b0 && t < 10) begin @(negedge clk); t++; end
    n_checks++; if (!(dir === 1'b0 && t <= 4)) $display("FAIL rd_dir_off: got dir=%b after %0d clocks expected 0 within 4", dir, t); else n_pass++;
    n_checks++; if (dout !== 8'h5A) $display("FAIL rd_dout_keep: got %h expected 5a", dout); else n_pass++;
    n_checks++; if (hs_count - h0 !== 1 || log_wr[h0] !== 1'b0 || log_addr[h0] !== 2'd1)
      $display("FAIL rd_txn: got count=%0d wr=%b addr=%0d expected 1/0/1", hs_count - h0, log_wr[h0], log_addr[h0]);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignored();
    int h0;
    bit bad;
    h0 = hs_count; bad = 1'b0;
    @(negedge clk);
    a = 8'h98; din = 8'h33; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (8) begin @(negedge clk); if (bus_if.bus_valid !== 1'b0 || wait_o !== 1'b0 || dir !== 1'b0) bad = 1'b1; end
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (4) @(negedge clk);
    a = 8'h8C; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (8) begin @(negedge clk); if (bus_if.bus_valid !== 1'b0 || wait_o !== 1'b0 || dir !== 1'b0) bad = 1'b1; end
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (hs_count - h0 !== 0) $display("FAIL ign_count: got %0d expected 0", hs_count - h0); else n_pass++;
    n_checks++; if (bad !== 1'b0) $display("FAIL ign_outputs: got activity expected none"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [11];
    int h0;
    vals = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h44, 8'h00, 8'hC0};
    h0 = hs_count;
    bus_if.bus_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a = 8'h8B; din = vals[i]; iorq_n = 1'b0; wr_n = 1'b0;
      repeat (8) @(negedge clk);
      iorq_n = 1'b1; wr_n = 1'b1;
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_checks++; if (hs_count - h0 !== 11) $display("FAIL b2b_count: got %0d expected 11", hs_count - h0); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (log_addr[h0+i] !== 2'd3 || log_wr[h0+i] !== 1'b1 || log_wdata[h0+i] !== vals[i])
        $display("FAIL b2b_txn%0d: got addr=%0d wr=%b data=%h expected 3/1/%h",
                 i, log_addr[h0+i], log_wr[h0+i], log_wdata[h0+i], vals[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int h0, t;
    bit bad;
    h0 = hs_count;
    bus_if.bus_ready = 1'b0;
    @(negedge clk);
    a = 8'h88; din = 8'h3C; iorq_n = 1'b0; wr_n = 1'b0;
    t = 0;
    while (bus_if.bus_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    n_checks++; if (bus_if.bus_valid !== 1'b1) $display("FAIL stall_valid_rise: got %b expected 1", bus_if.bus_valid); else n_pass++;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus_if.bus_valid !== 1'b1 || bus_if.bus_address !== 2'd0 ||
          bus_if.bus_wdata !== 8'h3C || bus_if.bus_write !== 1'b1) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL stall_stable: got payload change expected stable"); else n_pass++;
    n_checks++; if (hs_count - h0 !== 0) $display("FAIL stall_early_hs: got %0d expected 0", hs_count - h0); else n_pass++;
    bus_if.bus_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_if.bus_valid !== 1'b0) $display("FAIL stall_valid_drop: got %b expected 0", bus_if.bus_valid); else n_pass++;
    n_checks++; if (hs_count - h0 !== 1) $display("FAIL stall_hs: got %0d expected 1", hs_count - h0); else n_pass++;
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int h0, t;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata_en = 1'b0;
    h0 = hs_count;
    @(negedge clk);
    a = 8'h89; iorq_n = 1'b0; rd_n = 1'b0;
    t = 0;
    while (hs_count == h0 && t < 10) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    n_checks++; if (wait_o !== 1'b1) $display("FAIL rst_mid_pre_wait: got %b expected 1", wait_o); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (wait_o !== 1'b0) $display("FAIL rst_mid_wait: got %b expected 0", wait_o); else n_pass++;
    n_checks++; if (dir !== 1'b0) $display("FAIL rst_mid_dir: got %b expected 0", dir); else n_pass++;
    n_checks++; if (bus_if.bus_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", bus_if.bus_valid); else n_pass++;
    iorq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    // Fresh read after reset
    h0 = hs_count;
    a = 8'h89; iorq_n = 1'b0; rd_n = 1'b0;
    t = 0;
    while (hs_count == h0 && t < 10) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    bus_if.bus_rdata = 8'hA7; bus_if.bus_rdata_en = 1'b1;
    @(negedge clk);
    bus_if.bus_rdata_en = 1'b0;
    n_checks++; if (dout !== 8'hA7 || dir !== 1'b1 || wait_o !== 1'b0)
      $display("FAIL rst_post_read: got dout=%h dir=%b wait=%b expected a7/1/0", dout, dir, wait_o);
    else n_pass++;
    iorq_n = 1'b1; rd_n = 1'b1;
    t = 0;
    while (dir !== 1'b0 && t < 10) begin @(negedge clk); t++; end
    n_checks++; if (dir !== 1'b0) $display("FAIL rst_post_dir_off: got %b expected 0", dir); else n_pass++;
    n_checks++; if (hs_count - h0 !== 1) $display("FAIL rst_post_hs: got %0d expected 1", hs_count - h0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignored();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
